accumulator_unit_n: RTL
=======================

Name: accumulator_unit_n

Overview:
- Parametrised accumulator register for the datapath; successor to the fixed 4-bit accumulator.
- Holds register A and feeds it continuously to the ALU input.
- Drives A onto the shared tri-state bus on request.
- Adds single-cycle arithmetic/rotate ops, a multi-cycle shift-by-N engine with a ready/valid handshake, a shadow register for swap, and status flags.

Parameters:
- WIDTH, 8, accumulator/bus width in bits (≥2).
- SHW, $clog2(WIDTH)+1, width of the shift-amount field; holds 0..WIDTH.

Ports:
- MainClock  input  1  system clock, all state on rising edge
- Reset  input  1  synchronous, active-high reset
- Op  input  4  operation code (encodings in package)
- OpValid  input  1  Op/operands presented this cycle
- OpReady  output  1  unit can accept an op this cycle
- DataIn  input  WIDTH  load operand, from bus or ALU result
- ShAmt  input  SHW  bit count for SHIFT_N
- ShDir  input  1  SHIFT_N direction: 0 = left, 1 = right (logical)
- BusEnable  input  1  drive A onto bus
- BusOut  output  WIDTH  A when BusEnable=1, else high-Z on every bit
- AluA  output  WIDTH  current A, always driven
- Zero  output  1  A == 0
- Negative  output  1  A[WIDTH-1]
- Carry  output  1  carry/borrow/last-bit-out flag

Interface decision: one clock; reset is synchronous and active-high (MainClock, Reset).

Behaviour:
- Reset, on a rising edge with Reset=1, overrides everything:
  - A = 0, Shadow = 0, Carry = 0
  - state = IDLE, count = 0
  - OpReady = 1 in the following cycle
- Accept rule:
  - An op is accepted on an edge where OpValid=1 and OpReady=1.
  - OpValid while OpReady=0 is ignored: no effect, not queued.
  - The source must hold OpValid until it sees OpReady=1.
- Single-cycle ops: A and Carry update on the accepting edge; OpReady stays 1.
  - NOP: no change.
  - LOAD: A = DataIn; Carry = 0.
  - CLEAR: A = 0; Carry = 0.
  - INC: {Carry, A} = A + 1, mod 2^WIDTH. Example: all-ones → 0, Carry=1.
  - DEC: A = A - 1. Carry = 1 iff A was 0 (borrow). 0 → all-ones.
  - SHL / SHR: one-bit logical shift. Carry = bit shifted out.
  - ROL / ROR: one-bit rotate. Carry = bit moved across the end.
  - SWAP: A and Shadow exchange simultaneously.
  - STORE: Shadow = A; A unchanged.
  - Undefined codes behave as NOP.
- SHIFT_N, two-state FSM IDLE / SHIFTING:
  - On acceptance in IDLE, latch ShAmt into count and ShDir into dir.
  - ShAmt = 0: behaves as NOP. Stays IDLE, OpReady stays 1, Carry unchanged.
  - ShAmt > 0: enter SHIFTING; OpReady = 0 from the next cycle.
  - Each edge in SHIFTING: shift A one bit in dir, Carry = bit out, count = count - 1.
  - When count reaches 0, return to IDLE; OpReady = 1 in that cycle.
  - Total: ShAmt edges of shifting, ShAmt busy cycles, then ready.
  - ShAmt ≥ WIDTH is legal: A becomes 0; Carry = last bit out (0 if ShAmt > WIDTH).
  - Reset during SHIFTING aborts immediately to reset values.
- Bus and flags:
  - BusOut is a pure function of registered A and BusEnable; no clock involvement.
  - During SHIFTING the bus shows intermediate A values; the controller must not enable the bus while OpReady=0.
  - Zero, Negative and AluA are combinational from registered A.
  - Carry is registered.
- Only one op per cycle; no simultaneous load + shift.

Decomposition:
- Package accumulator_pkg:
  - Op encodings: NOP=0, LOAD=1, CLEAR=2, INC=3, DEC=4, SHL=5, SHR=6, ROL=7, ROR=8, SWAP=9, STORE=10, SHIFT_N=11.
  - FSM state enum {IDLE, SHIFTING}.
- One combinational sub-module, accumulator_shift1:
  - Inputs: A, dir, rotate.
  - Outputs: shifted A, bit-out.
  - Reused by the single-bit ops and the SHIFT_N engine.
- Top module holds the registers, FSM, flags and tri-state driver.

Test Plan (WIDTH=8):
1. Reset, then LOAD 0xA5 → AluA=0xA5, Carry=0, Zero=0, Negative=1. BusEnable=0 → BusOut=ZZ; BusEnable=1 → BusOut=0xA5.
2. LOAD 0xFF, INC → A=0x00, Carry=1, Zero=1. Then DEC → A=0xFF, Carry=1. Then DEC → A=0xFE, Carry=0.
3. LOAD 0x81, ROL → A=0x03, Carry=1. SHR → A=0x01, Carry=1. ROR → A=0x80, Carry=1.
4. LOAD 0x0F, SHIFT_N ShAmt=3 ShDir=0:
   - OpReady low for 3 cycles.
   - A steps 0x1E, 0x3C, 0x78; Carry=0 throughout.
   - OpReady returns high.
   - An INC presented mid-shift is ignored.
5. SHIFT_N ShAmt=0 → one-cycle NOP, OpReady never drops. ShAmt=9 on 0xFF → after 9 cycles A=0x00, Carry=0.
6. LOAD 0x12, STORE, LOAD 0x34, SWAP → A=0x12; then SWAP → A=0x34. Start SHIFT_N ShAmt=5 and assert Reset on busy cycle 2 → next cycle A=0, Shadow=0, OpReady=1.

Source files
------------

// File: rtl/accumulator_pkg.sv
// Shared definitions for the parametrised accumulator: op encodings and FSM states.
package accumulator_pkg;

   typedef enum logic [3:0] {
      OP_NOP     = 4'd0,
      OP_LOAD    = 4'd1,
      OP_CLEAR   = 4'd2,
      OP_INC     = 4'd3,
      OP_DEC     = 4'd4,
      OP_SHL     = 4'd5,
      OP_SHR     = 4'd6,
      OP_ROL     = 4'd7,
      OP_ROR     = 4'd8,
      OP_SWAP    = 4'd9,
      OP_STORE   = 4'd10,
      OP_SHIFT_N = 4'd11
   } op_e;

   typedef enum logic {
      IDLE,
      SHIFTING
   } state_e;

endpackage

// File: rtl/accumulator_shift1.sv
// One-bit logical shift / rotate of the accumulator, shared by the single-cycle
// ops and the SHIFT_N engine. dir: 0 = left, 1 = right.
module accumulator_shift1 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic             dir,
   input  logic             rotate,
   output logic [WIDTH-1:0] shifted,
   output logic             bit_out
);

   always_comb begin
      shifted = a;
      bit_out = 1'b0;
      if (dir) begin
         shifted = {rotate ? a[0] : 1'b0, a[WIDTH-1:1]};
         bit_out = a[0];
      end else begin
         shifted = {a[WIDTH-2:0], rotate ? a[WIDTH-1] : 1'b0};
         bit_out = a[WIDTH-1];
      end
   end

endmodule

// File: rtl/accumulator_unit_n.sv
// Accumulator register A with shadow swap, status flags, tri-state bus driver
// and a multi-cycle shift-by-N engine behind a ready/valid handshake.
module accumulator_unit_n
   import accumulator_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SHW   = $clog2(WIDTH) + 1
) (
   input  logic             MainClock,
   input  logic             Reset,
   input  logic [3:0]       Op,
   input  logic             OpValid,
   output logic             OpReady,
   input  logic [WIDTH-1:0] DataIn,
   input  logic [SHW-1:0]   ShAmt,
   input  logic             ShDir,
   input  logic             BusEnable,
   output logic [WIDTH-1:0] BusOut,
   output logic [WIDTH-1:0] AluA,
   output logic             Zero,
   output logic             Negative,
   output logic             Carry
);

   state_e           state_q, state_n;
   logic [WIDTH-1:0] a_q, a_n;
   logic [WIDTH-1:0] shadow_q, shadow_n;
   logic             carry_q, carry_n;
   logic             ready_q, ready_n;
   logic [SHW-1:0]   count_q, count_n;
   logic             dir_q, dir_n;

   logic [WIDTH-1:0] sh_y;
   logic             sh_out;
   logic             sh_dir, sh_rot;

   // Shifter direction comes from the latched SHIFT_N dir while busy, else from the op.
   assign sh_dir = (state_q == SHIFTING) ? dir_q : (Op == OP_SHR || Op == OP_ROR);
   assign sh_rot = (state_q == IDLE) && (Op == OP_ROL || Op == OP_ROR);

   accumulator_shift1 #(.WIDTH(WIDTH)) u_shift1 (
      .a       (a_q),
      .dir     (sh_dir),
      .rotate  (sh_rot),
      .shifted (sh_y),
      .bit_out (sh_out)
   );

   always_ff @(posedge MainClock) begin
      if (Reset) begin
         state_q  <= IDLE;
         a_q      <= '0;
         shadow_q <= '0;
         carry_q  <= 1'b0;
         ready_q  <= 1'b1;
         count_q  <= '0;
         dir_q    <= 1'b0;
      end else begin
         state_q  <= state_n;
         a_q      <= a_n;
         shadow_q <= shadow_n;
         carry_q  <= carry_n;
         ready_q  <= ready_n;
         count_q  <= count_n;
         dir_q    <= dir_n;
      end
   end

   always_comb begin
      state_n  = state_q;
      a_n      = a_q;
      shadow_n = shadow_q;
      carry_n  = carry_q;
      count_n  = count_q;
      dir_n    = dir_q;
      case (state_q)
         IDLE: begin
            if (OpValid && ready_q) begin
               case (op_e'(Op))
                  OP_LOAD:  begin a_n = DataIn; carry_n = 1'b0; end
                  OP_CLEAR: begin a_n = '0;     carry_n = 1'b0; end
                  OP_INC:   {carry_n, a_n} = {1'b0, a_q} + (WIDTH+1)'(1);
                  OP_DEC: begin
                     a_n     = a_q - WIDTH'(1);
                     carry_n = (a_q == '0);
                  end
                  OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
                     a_n     = sh_y;
                     carry_n = sh_out;
                  end
                  OP_SWAP:  begin a_n = shadow_q; shadow_n = a_q; end
                  OP_STORE: shadow_n = a_q;
                  OP_SHIFT_N: begin
                     count_n = ShAmt;
                     dir_n   = ShDir;
                     if (ShAmt != '0) state_n = SHIFTING;
                  end
                  default: ;
               endcase
            end
         end
         SHIFTING: begin
            a_n     = sh_y;
            carry_n = sh_out;
            count_n = count_q - SHW'(1);
            if (count_q == SHW'(1)) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign ready_n  = (state_n == IDLE);

   assign OpReady  = ready_q;
   assign Carry    = carry_q;
   assign AluA     = a_q;
   assign Zero     = (a_q == '0);
   assign Negative = a_q[WIDTH-1];
   assign BusOut   = BusEnable ? a_q : {WIDTH{1'bz}};

endmodule
